aes_enc_ctrl: RTL and testbench

Iterative sequencer for the AES-128 encryption datapath. It accepts one plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then drives one shared combinational round unit (SubBytes → ShiftRows → MixColumns → AddRoundKey, plus Key expansion) for 10 consecutive cycles and presents the ciphertext over a second valid/ready handshake. It replaces the 10× unrolled round pipeline wherever area matters more than throughput.

---
 rtl/aes_pkg.sv | 137 +++++++++++++
 rtl/aes_round_model.sv | 27 ++
 rtl/aes_enc_ctrl.sv | 122 ++++++++++++
 tb/tb_aes_enc_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the iterative AES-128 encryptor.
//   AES_ROUNDS    : number of AES-128 rounds.
//   block_t       : one 128-bit block or key.
//   bytes_t       : the same block viewed as 16 bytes; bytes_t[15] is byte 0.
//   ctrl_state_t  : sequencer states IDLE / ROUND / DONE.
//   FIPS_*        : FIPS-197 reference vectors (appendix B and C.1).
//   Functions     : GF(2^8) arithmetic, S-box, one AES round and one
//                   key-expansion step, used by the behavioural round unit.
//
// Byte order follows FIPS-197: byte 0 is bits [127:120]. The state is
// column-major, so byte (row r, column c) is byte index r + 4*c.
package aes_pkg;

  localparam int AES_ROUNDS = 10;

  typedef logic [127:0]      block_t;
  typedef logic [15:0][7:0]  bytes_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  localparam block_t FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam block_t FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam block_t FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t FIPS_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam block_t FIPS_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t FIPS_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  // Index into bytes_t for (row r, column c).
  function automatic logic [3:0] bi(input int r, input int c);
    return 4'(15 - r - 4 * c);
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    logic [7:0] y;
    acc = 8'h00;
    x   = a;
    y   = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) acc = acc ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return acc;
  endfunction

  // S-box computed from its definition: multiplicative inverse (x^254,
  // which maps 0 to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] inv;
    p   = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for key-expansion step rc (0 -> 01, 9 -> 36).
  function automatic logic [7:0] rcon_of(input logic [3:0] rc);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 15; i++) begin
      if (i < int'(rc)) r = xtime(r);
    end
    return r;
  endfunction

  // SubBytes followed by ShiftRows.
  function automatic block_t sub_shift(input block_t s);
    bytes_t ib;
    bytes_t ob;
    ib = s;
    ob = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ob[bi(r, c)] = sbox(ib[bi(r, (c + r) % 4)]);
      end
    end
    return ob;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    bytes_t ib;
    bytes_t ob;
    logic [7:0] a0, a1, a2, a3;
    ib = s;
    ob = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = ib[bi(0, c)];
      a1 = ib[bi(1, c)];
      a2 = ib[bi(2, c)];
      a3 = ib[bi(3, c)];
      ob[bi(0, c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      ob[bi(1, c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      ob[bi(2, c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      ob[bi(3, c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return ob;
  endfunction

  // One key-expansion step: round key rc -> round key rc+1.
  function automatic block_t key_expand(input block_t k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rcon_of(rc), sbox(w3[15:8]),
          sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One full round including AddRoundKey with the already expanded key.
  function automatic block_t aes_round(input block_t s, input block_t rk,
                                       input logic last);
    block_t t;
    t = sub_shift(s);
    if (!last) t = mix_columns(t);
    return t ^ rk;
  endfunction

endpackage

// File: rtl/aes_round_model.sv
// aes_round_model: combinational AES-128 round plus key-expansion step.
// Stands in for the external round unit (S-box ROM or composite-field
// implementation) that aes_enc_ctrl drives.
//   i_state : state entering the round
//   i_key   : previous round key
//   i_rc    : round index, selects the round constant
//   i_final : skip MixColumns
//   o_state : round result including AddRoundKey with o_key
//   o_key   : expanded round key
module aes_round_model
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  input  logic [3:0]   i_rc,
  input  logic         i_final,
  output logic [127:0] o_state,
  output logic [127:0] o_key
);

  logic [127:0] w_key;

  assign w_key   = key_expand(i_key, i_rc);
  assign o_key   = w_key;
  assign o_state = aes_round(i_state, w_key, i_final);

endmodule

// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl: iterative AES-128 encryption sequencer.
// Accepts a plaintext/key pair, applies the initial AddRoundKey, then steps
// an external combinational round unit once per cycle for ROUNDS cycles and
// offers the ciphertext.
//
// Ports:
//   clk, rst                : clock; asynchronous active-high reset
//   in_valid/in_ready       : input handshake, data_in = plaintext, key_in = key
//   out_valid/out_ready     : output handshake, cipher_out = ciphertext
//   rnd_state_o/rnd_key_o   : state and round key to the round unit
//   rnd_rc_o/rnd_final_o    : round index and last-round flag to the round unit
//   rnd_state_i/rnd_key_i   : round result and expanded key from the round unit
//   busy                    : a round sequence is running
//   dbg_state_o             : current FSM state (ctrl_state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE (and not before the first edge after reset),
// out_valid only in DONE, so neither depends combinationally on any input and
// the two are never high together. cipher_out is held until the transfer.
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int ROUNDS = AES_ROUNDS,
  parameter int W      = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_in,
  input  logic [W-1:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] cipher_out,
  output logic [W-1:0] rnd_state_o,
  output logic [W-1:0] rnd_key_o,
  output logic [3:0]   rnd_rc_o,
  output logic         rnd_final_o,
  input  logic [W-1:0] rnd_state_i,
  input  logic [W-1:0] rnd_key_i,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  ctrl_state_t  r_state;
  logic [W-1:0] r_data;
  logic [W-1:0] r_key;
  logic [3:0]   r_rnd;
  // Cleared by reset, set on the first edge after release; keeps in_ready
  // low while rst is high without a path from rst to the output.
  logic         r_live;

  ctrl_state_t  w_state_d;
  logic [W-1:0] w_data_d;
  logic [W-1:0] w_key_d;
  logic [3:0]   w_rnd_d;
  logic         w_in_ready;

  assign w_in_ready = (r_state == IDLE) && r_live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_key   <= w_key_d;
      r_rnd   <= w_rnd_d;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_key_d   = r_key;
    w_rnd_d   = r_rnd;
    case (r_state)
      IDLE: begin
        if (in_valid && w_in_ready) begin
          w_data_d  = data_in ^ key_in;
          w_key_d   = key_in;
          w_rnd_d   = 4'd0;
          w_state_d = ROUND;
        end
      end
      ROUND: begin
        w_data_d = rnd_state_i;
        w_key_d  = rnd_key_i;
        // The round index stops at the last round rather than wrapping.
        if (r_rnd == LAST_RND) begin
          w_state_d = DONE;
        end else begin
          w_rnd_d = r_rnd + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = (r_state == DONE);
  assign busy        = (r_state == ROUND);
  assign cipher_out  = r_data;
  assign rnd_state_o = r_data;
  assign rnd_key_o   = r_key;
  assign rnd_rc_o    = r_rnd;
  assign rnd_final_o = (r_state == ROUND) && (r_rnd == LAST_RND);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_aes_enc_ctrl.sv
// tb_aes_enc_ctrl: self-checking bench for aes_enc_ctrl with a behavioural
// AES round unit attached to the rnd_* ports.
module tb_aes_enc_ctrl;
  import aes_pkg::*;

  localparam int W = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and round unit ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] data_in  = '0;
  logic [W-1:0] key_in   = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] cipher_out;
  logic [W-1:0] rnd_state_o;
  logic [W-1:0] rnd_key_o;
  logic [3:0]   rnd_rc_o;
  logic         rnd_final_o;
  logic [W-1:0] rnd_state_i;
  logic [W-1:0] rnd_key_i;
  logic         busy;
  logic [1:0]   dbg_state;

  aes_enc_ctrl #(.ROUNDS(AES_ROUNDS), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .key_in      (key_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cipher_out  (cipher_out),
    .rnd_state_o (rnd_state_o),
    .rnd_key_o   (rnd_key_o),
    .rnd_rc_o    (rnd_rc_o),
    .rnd_final_o (rnd_final_o),
    .rnd_state_i (rnd_state_i),
    .rnd_key_i   (rnd_key_i),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  aes_round_model u_round (
    .i_state (rnd_state_o),
    .i_key   (rnd_key_o),
    .i_rc    (rnd_rc_o),
    .i_final (rnd_final_o),
    .o_state (rnd_state_i),
    .o_key   (rnd_key_i)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int acc_cyc = 0;
  logic [W-1:0] exp_q[$];

  // Whole-block AES-128: initial AddRoundKey then ten rounds, last without
  // MixColumns, key schedule advanced one step per round.
  function automatic block_t aes_ref(input block_t pt, input block_t key);
    block_t s;
    block_t k;
    s = pt ^ key;
    k = key;
    for (int r = 0; r < AES_ROUNDS; r++) begin
      k = key_expand(k, 4'(r));
      s = aes_round(s, k, r == AES_ROUNDS - 1);
    end
    return s;
  endfunction

  function automatic block_t rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input block_t obs, input block_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; waits (bounded) for in_ready, offers the pair for
  // one edge, returns at the negedge after the accept edge.
  task automatic drive_in(input block_t pt, input block_t key, input string tag);
    int waited = 0;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk_bit({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    data_in  = pt;
    key_in   = key;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = rand_blk();
    key_in   = rand_blk();
    acc_cyc  = cyc;
    exp_q.push_back(aes_ref(pt, key));
  endtask

  // Starts at the negedge right after the accept edge. Checks the round
  // index sequence and that out_valid appears 10 edges after accept.
  // abort_at >= 0 returns early at that round index.
  task automatic watch_rounds(input string tag, input int abort_at);
    for (int k = 0; k < AES_ROUNDS; k++) begin
      chk_bit({tag, "_busy"}, busy, 1'b1);
      chk_int({tag, "_rc"}, int'(rnd_rc_o), k);
      chk_bit({tag, "_final"}, rnd_final_o, k == AES_ROUNDS - 1);
      chk_bit({tag, "_no_in_ready"}, in_ready, 1'b0);
      chk_bit({tag, "_no_out_valid"}, out_valid, 1'b0);
      if (k == abort_at) return;
      @(negedge clk);
    end
    chk_int({tag, "_latency"}, cyc - acc_cyc, 10);
    chk_bit({tag, "_out_valid"}, out_valid, 1'b1);
    chk_bit({tag, "_busy_done"}, busy, 1'b0);
  endtask

  // Starts at the first DONE negedge. Keeps out_ready low for `hold` cycles,
  // then takes the ciphertext and checks the return to IDLE.
  task automatic drain(input int hold, input string tag);
    block_t exp;
    exp = (exp_q.size() != 0) ? exp_q[0] : '0;
    out_ready = (hold == 0);
    for (int i = 0; i <= hold; i++) begin
      chk_bit({tag, "_valid"}, out_valid, 1'b1);
      chk_blk({tag, "_ct"}, cipher_out, exp);
      chk_bit({tag, "_in_ready_low"}, in_ready, 1'b0);
      chk_bit({tag, "_final_low"}, rnd_final_o, 1'b0);
      if (i == hold) out_ready = 1'b1;
      @(negedge clk);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    chk_bit({tag, "_valid_clr"}, out_valid, 1'b0);
    chk_bit({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int prev_acc;
    block_t pa;
    block_t ka;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_bit("rst_in_ready", in_ready, 1'b0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_blk("rst_cipher", cipher_out, '0);
    chk_int("rst_rc", int'(rnd_rc_o), 0);
    chk_int("rst_fsm", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk_bit("rel_in_ready", in_ready, 1'b1);

    // FIPS-197 C.1 with latency
    drive_in(FIPS_C1_PT, FIPS_C1_KEY, "c1");
    watch_rounds("c1", -1);
    chk_blk("c1_fips", cipher_out, FIPS_C1_CT);
    drain(0, "c1");

    // FIPS-197 B with 5 cycles of backpressure
    drive_in(FIPS_B_PT, FIPS_B_KEY, "b");
    watch_rounds("b", -1);
    chk_blk("b_fips", cipher_out, FIPS_B_CT);
    drain(5, "b_bp");

    // Second pair offered while busy: held off until IDLE
    drive_in(FIPS_B_PT, FIPS_B_KEY, "busy_a");
    in_valid = 1'b1;
    data_in  = FIPS_C1_PT;
    key_in   = FIPS_C1_KEY;
    watch_rounds("busy_a", -1);
    chk_blk("busy_a_fips", cipher_out, FIPS_B_CT);
    drain(0, "busy_a");
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc  = cyc;
    exp_q.push_back(aes_ref(FIPS_C1_PT, FIPS_C1_KEY));
    chk_bit("busy_b_taken", busy, 1'b1);
    watch_rounds("busy_b", -1);
    chk_blk("busy_b_fips", cipher_out, FIPS_C1_CT);
    drain(1, "busy_b");

    // Reset at round 4
    drive_in(FIPS_C1_PT, FIPS_C1_KEY, "mid");
    watch_rounds("mid", 4);
    rst = 1'b1;
    #1;
    chk_bit("mid_rst_busy", busy, 1'b0);
    chk_bit("mid_rst_out_valid", out_valid, 1'b0);
    chk_bit("mid_rst_in_ready", in_ready, 1'b0);
    chk_blk("mid_rst_cipher", cipher_out, '0);
    chk_int("mid_rst_rc", int'(rnd_rc_o), 0);
    exp_q.delete();
    @(negedge clk);
    chk_bit("mid_rst_hold_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_bit("mid_rel_in_ready", in_ready, 1'b1);
    chk_bit("mid_rel_out_valid", out_valid, 1'b0);
    drive_in(FIPS_C1_PT, FIPS_C1_KEY, "post_rst");
    watch_rounds("post_rst", -1);
    chk_blk("post_rst_fips", cipher_out, FIPS_C1_CT);
    drain(0, "post_rst");

    // Back-to-back with out_ready tied high: 12 cycles per block
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int v = 0; v < 4; v++) begin
      case (v)
        0:       begin pa = FIPS_C1_PT; ka = FIPS_C1_KEY; end
        1:       begin pa = FIPS_B_PT;  ka = FIPS_B_KEY;  end
        default: begin pa = rand_blk(); ka = rand_blk();  end
      endcase
      drive_in(pa, ka, "b2b");
      if (v > 0) chk_int("b2b_period", acc_cyc - prev_acc, 12);
      prev_acc = acc_cyc;
      watch_rounds("b2b", -1);
      drain(0, "b2b");
    end

    // Random pairs with random backpressure
    for (int v = 0; v < 6; v++) begin
      drive_in(rand_blk(), rand_blk(), "rnd");
      watch_rounds("rnd", -1);
      drain(int'($urandom_range(0, 3)), "rnd");
    end

    // Final report
    chk_int("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
